ddr_port_arbiter: RTL and testbench
===================================

DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 8, giving the maximum number of outstanding DDR reads (power of 2).
REQ-002 SHALL have ports `clock` (input, 1), the single rising-edge clock, and `reset` (input, 1), asynchronous and active-low.
REQ-003 SHALL have per-client ports for N in {0,1}, where client 0 is the coherent memory FSM:
- `cN_req` in 1: request the port.
- `cN_gnt` out 1: client owns the port.
- `cN_wrAF` in 1, `cN_afAddress` in 26, `cN_afRead` in 1: address FIFO command.
- `cN_wrWB` in 1, `cN_writeData` in 128: write buffer word.
- `cN_afFull` out 1, `cN_wbFull` out 1: client-side backpressure.
- `cN_rbEmpty` out 1, `cN_rdRB` in 1, `cN_readData` out 128: read buffer.
REQ-004 SHALL have DDR-side ports `afFull` in 1, `wbFull` in 1, `wrAF` out 1, `afAddress` out 26, `afRead` out 1, `wrWB` out 1, `writeData` out 128, `rbEmpty` in 1, `rdRB` out 1 and `readData` in 128.
REQ-005 SHALL have port `protoErr` out 1, a sticky protocol-violation flag.

Function
REQ-006 SHALL implement FSM states IDLE, OWN0 and OWN1.
REQ-007 In IDLE with a single requester, the FSM SHALL enter OWNn; `cN_gnt` is registered and rises the cycle after `cN_req` is sampled.
REQ-008 In IDLE with both clients requesting, the FSM SHALL grant the client not served last (round-robin); the lastServed pointer resets to 1, so client 0 wins the first tie.
REQ-009 In OWNn, DDR AF/WB outputs SHALL mux client n; the non-owner sees `afFull`=`wbFull`=1 and its `wrAF`/`wrWB` are ignored.
REQ-010 The owner SHALL see `afFull` = DDR `afFull` OR tagCount==TAG_DEPTH, and `wbFull` = DDR `wbFull`.
REQ-011 A write or AF command SHALL be accepted only when it is asserted and the owner's corresponding full signal is low; DDR `wrAF`/`wrWB` SHALL pulse only on acceptance.
REQ-012 An accepted owner `wrAF` SHALL end the transaction: the FSM returns to IDLE the next cycle, `gnt` drops, and lastServed becomes n.
REQ-013 If the owner deasserts `req` while wbCount==0 and it has issued no `wrAF`, ownership SHALL be released the same way, without a DDR command.
REQ-014 The 2-bit wbCount SHALL count accepted `wrWB` beats within the grant and clear on release; a third beat saturates and sets `protoErr`.
REQ-015 An accepted write AF (`afRead`=0) with wbCount plus same-cycle beat not equal to 2 SHALL set `protoErr`.
REQ-016 An accepted read AF with wbCount not 0 SHALL set `protoErr`.
REQ-017 On each accepted read AF, the owner id SHALL be pushed into the tag FIFO.
REQ-018 The tag FIFO head SHALL own read return; `cH_rbEmpty` = DDR `rbEmpty` OR tagEmpty, and the other client sees `rbEmpty`=1.
REQ-019 `readData` SHALL be broadcast combinationally to both clients.
REQ-020 DDR `rdRB` SHALL equal head client `rdRB` AND NOT `cH_rbEmpty`; non-head `rdRB` is ignored.
REQ-021 A beat toggle SHALL flip on each DDR `rdRB`; the second beat pops the tag.
REQ-022 A simultaneous tag push and pop SHALL leave tagCount unchanged; a push is never attempted when full, per REQ-010.
REQ-023 Read return SHALL be independent of the AF FSM: returns to one client proceed while the other owns AF/WB.
REQ-024 All data-path muxing SHALL be combinational, with zero-cycle latency from the owner to DDR.

Reset
REQ-025 On `reset` low, asynchronously: state=IDLE, both `gnt`=0, lastServed=1, wbCount=0, tag FIFO empty, beat=0, `protoErr`=0.
REQ-026 During reset, DDR `wrAF`, `wrWB` and `rdRB` SHALL be 0, both client `afFull`/`wbFull`=1 and both client `rbEmpty`=1.
REQ-027 Reset asserted mid-transaction SHALL discard all outstanding tags; reads in flight at DDR are the system's responsibility.

Structure
REQ-028 A shared package SHALL hold TAG_DEPTH default, client-id width, beats-per-line (2) and the FSM state encoding.
REQ-029 The tag FIFO SHALL be a sub-module `ddr_tag_fifo` (1-bit entries, count output, async active-low reset).

Verification
REQ-030 Client 0 req, 2 `wrWB` then write `wrAF` to 26'h0000040 -> `gnt0` the next cycle; DDR sees 2 WB writes and 1 AF with `afRead`=0; `gnt0` drops; `protoErr`=0.
REQ-031 Both clients req every cycle, each issuing reads -> grants alternate 0,1,0,1 with client 0 first.
REQ-032 Client 1 read AF, then client 0 read AF, with DDR returning 4 beats -> beats 1-2 reach client 1 (`c0_rbEmpty`=1 throughout) and beats 3-4 reach client 0.
REQ-033 With TAG_DEPTH=8, issue 8 reads without draining -> owner `afFull`=1; one 2-beat drain -> `afFull`=0.
REQ-034 Write AF after 1 WB beat -> `protoErr`=1, staying 1 until reset.
REQ-035 Assert `reset` low with 3 tags outstanding -> tagCount=0, `gnt`=0 and `rbEmpty`=1 to both clients immediately.

Source files
------------

// File: rtl/ddr_port_arbiter_pkg.sv
// Shared definitions for the two-client DDR port arbiter.
// Holds the default read-tag depth, the client id width, the number of
// 128-bit beats that make up one cache line, and the arbiter state encoding.
package ddr_port_arbiter_pkg;

  localparam int TAG_DEPTH_DEFAULT = 8;
  localparam int CLIENT_ID_W       = 1;
  localparam int BEATS_PER_LINE    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arbState_t;

endpackage

// File: rtl/ddr_tag_fifo.sv
// Read-tag FIFO: remembers which client issued each outstanding DDR read so
// returned data can be steered back in issue order.
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-low reset
//   push, pushId   enqueue the id of a client whose read was accepted
//   pop            dequeue the head once its line has fully returned
//   headId         client owning the oldest outstanding read
//   empty          no reads outstanding
//   count          number of outstanding reads (0..DEPTH)
module ddr_tag_fifo
  import ddr_port_arbiter_pkg::*;
#(
  parameter int DEPTH = TAG_DEPTH_DEFAULT,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [CLIENT_ID_W-1:0] pushId,
  input  logic                   pop,
  output logic [CLIENT_ID_W-1:0] headId,
  output logic                   empty,
  output logic [CW-1:0]          count
);

  logic [CLIENT_ID_W-1:0] mem [DEPTH];
  logic [PW-1:0]          wrPtr;
  logic [PW-1:0]          rdPtr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage is data only; stale entries are never read while empty.
  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= pushId;
  end

  assign headId = mem[rdPtr];
  assign empty  = (count == '0);

endmodule

// File: rtl/ddr_port_arbiter.sv
// Two-client arbiter in front of a single DDR controller port.
// Client 0 is the coherent memory FSM. One client at a time owns the
// address FIFO / write buffer path (round-robin on ties); read returns are
// routed independently, in issue order, through a tag FIFO.
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   cN_req / cN_gnt              ownership request / registered grant
//   cN_wrAF, cN_afAddress, cN_afRead   address FIFO command from client N
//   cN_wrWB, cN_writeData        write buffer beat from client N
//   cN_afFull, cN_wbFull         backpressure seen by client N
//   cN_rbEmpty, cN_rdRB, cN_readData   read buffer view of client N
//   afFull..readData             DDR controller side of the port
//   protoErr                     sticky protocol-violation flag
module ddr_port_arbiter
  import ddr_port_arbiter_pkg::*;
#(
  parameter int TAG_DEPTH = TAG_DEPTH_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         c0_req,
  output logic         c0_gnt,
  input  logic         c0_wrAF,
  input  logic [25:0]  c0_afAddress,
  input  logic         c0_afRead,
  input  logic         c0_wrWB,
  input  logic [127:0] c0_writeData,
  output logic         c0_afFull,
  output logic         c0_wbFull,
  output logic         c0_rbEmpty,
  input  logic         c0_rdRB,
  output logic [127:0] c0_readData,
  input  logic         c1_req,
  output logic         c1_gnt,
  input  logic         c1_wrAF,
  input  logic [25:0]  c1_afAddress,
  input  logic         c1_afRead,
  input  logic         c1_wrWB,
  input  logic [127:0] c1_writeData,
  output logic         c1_afFull,
  output logic         c1_wbFull,
  output logic         c1_rbEmpty,
  input  logic         c1_rdRB,
  output logic [127:0] c1_readData,
  input  logic         afFull,
  input  logic         wbFull,
  output logic         wrAF,
  output logic [25:0]  afAddress,
  output logic         afRead,
  output logic         wrWB,
  output logic [127:0] writeData,
  input  logic         rbEmpty,
  output logic         rdRB,
  input  logic [127:0] readData,
  output logic         protoErr
);

  localparam int             CW         = $clog2(TAG_DEPTH) + 1;
  localparam logic [CW-1:0]  TAG_MAX    = CW'(TAG_DEPTH);
  localparam logic [2:0]     LINE_BEATS = 3'(BEATS_PER_LINE);

  arbState_t              state;
  logic                   lastServed;
  logic [1:0]             wbCount;
  logic                   beat;
  logic [CW-1:0]          tagCount;
  logic [CLIENT_ID_W-1:0] headId;
  logic                   tagEmpty;

  // Saturating write-beat counter: a stray extra beat must not wrap to 0.
  function automatic logic [1:0] wbSatInc(input logic [1:0] cnt, input logic inc);
    if (inc && (cnt != 2'b11)) return cnt + 2'd1;
    return cnt;
  endfunction

  // Owner-side request path, selected combinationally by the current state.
  logic own1, owning, ownReq, ownWrAF, ownAfRead, ownWrWB, ownAfFull, tagFull;
  assign own1      = (state == OWN1);
  assign owning    = (state != IDLE);
  assign ownReq    = own1 ? c1_req    : c0_req;
  assign ownWrAF   = own1 ? c1_wrAF   : c0_wrAF;
  assign ownAfRead = own1 ? c1_afRead : c0_afRead;
  assign ownWrWB   = own1 ? c1_wrWB   : c0_wrWB;
  assign tagFull   = (tagCount == TAG_MAX);
  assign ownAfFull = afFull | tagFull;

  logic afAcc, wbAcc, relOwn;
  logic [2:0] wbSum;
  assign afAcc  = owning & ownWrAF & ~ownAfFull;
  assign wbAcc  = owning & ownWrWB & ~wbFull;
  assign wbSum  = {1'b0, wbCount} + {2'b00, wbAcc};
  // Ownership ends on an accepted command, or on an idle walk-away.
  assign relOwn = afAcc | (~ownReq & (wbCount == 2'd0) & ~wbAcc);

  logic errBeat, errWrAF, errRdAF;
  assign errBeat = wbAcc & (wbCount >= 2'd2);
  assign errWrAF = afAcc & ~ownAfRead & (wbSum != LINE_BEATS);
  assign errRdAF = afAcc & ownAfRead & (wbCount != 2'd0);

  // Non-owners are held off with full; IDLE (and reset) holds both off.
  assign c0_afFull = (state == OWN0) ? ownAfFull : 1'b1;
  assign c0_wbFull = (state == OWN0) ? wbFull    : 1'b1;
  assign c1_afFull = own1 ? ownAfFull : 1'b1;
  assign c1_wbFull = own1 ? wbFull    : 1'b1;

  assign wrAF      = afAcc;
  assign afAddress = own1 ? c1_afAddress : c0_afAddress;
  assign afRead    = ownAfRead;
  assign wrWB      = wbAcc;
  assign writeData = own1 ? c1_writeData : c0_writeData;

  // Read return: the tag FIFO head owns the read buffer.
  logic hRbEmpty, headRdRB, tagPush, tagPop;
  assign hRbEmpty    = rbEmpty | tagEmpty;
  assign c0_rbEmpty  = (headId == 1'b0) ? hRbEmpty : 1'b1;
  assign c1_rbEmpty  = (headId == 1'b1) ? hRbEmpty : 1'b1;
  assign headRdRB    = (headId == 1'b1) ? c1_rdRB : c0_rdRB;
  assign rdRB        = headRdRB & ~hRbEmpty;
  assign c0_readData = readData;
  assign c1_readData = readData;
  assign tagPush     = afAcc & ownAfRead;
  assign tagPop      = rdRB & beat;

  ddr_tag_fifo #(.DEPTH(TAG_DEPTH)) uTagFifo (
    .clock  (clock),
    .reset  (reset),
    .push   (tagPush),
    .pushId (own1),
    .pop    (tagPop),
    .headId (headId),
    .empty  (tagEmpty),
    .count  (tagCount)
  );

  // Beat parity within the current returning line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    beat <= 1'b0;
    else if (rdRB) beat <= ~beat;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      c0_gnt     <= 1'b0;
      c1_gnt     <= 1'b0;
      lastServed <= 1'b1;
      wbCount    <= 2'd0;
      protoErr   <= 1'b0;
    end else begin
      if (errBeat | errWrAF | errRdAF) protoErr <= 1'b1;
      case (state)
        IDLE: begin
          // On a tie, lastServed==1 favours client 0, otherwise client 1.
          if (c0_req && (!c1_req || lastServed)) begin
            state  <= OWN0;
            c0_gnt <= 1'b1;
          end else if (c1_req) begin
            state  <= OWN1;
            c1_gnt <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          if (relOwn) begin
            state      <= IDLE;
            c0_gnt     <= 1'b0;
            c1_gnt     <= 1'b0;
            lastServed <= own1;
            wbCount    <= 2'd0;
          end else begin
            wbCount <= wbSatInc(wbCount, wbAcc);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
module tb_ddr_port_arbiter;

  logic clock, reset;
  logic c0_req, c0_gnt, c0_wrAF, c0_afRead, c0_wrWB, c0_afFull, c0_wbFull, c0_rbEmpty, c0_rdRB;
  logic [25:0] c0_afAddress;
  logic [127:0] c0_writeData, c0_readData;
  logic c1_req, c1_gnt, c1_wrAF, c1_afRead, c1_wrWB, c1_afFull, c1_wbFull, c1_rbEmpty, c1_rdRB;
  logic [25:0] c1_afAddress;
  logic [127:0] c1_writeData, c1_readData;
  logic afFull, wbFull, wrAF, afRead, wrWB, rbEmpty, rdRB, protoErr;
  logic [25:0] afAddress;
  logic [127:0] writeData, readData;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [1:0]   kind;
    logic         flag;
    logic [25:0]  addr;
    logic [127:0] data;
  } rec_t;
  localparam logic [1:0] K_WB = 2'd1, K_AF = 2'd2, K_RD = 2'd3;

  rec_t expQ[$];
  rec_t evQ[$];
  rec_t expR;

  ddr_port_arbiter #(.TAG_DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .c0_req(c0_req), .c0_gnt(c0_gnt), .c0_wrAF(c0_wrAF), .c0_afAddress(c0_afAddress),
    .c0_afRead(c0_afRead), .c0_wrWB(c0_wrWB), .c0_writeData(c0_writeData),
    .c0_afFull(c0_afFull), .c0_wbFull(c0_wbFull), .c0_rbEmpty(c0_rbEmpty),
    .c0_rdRB(c0_rdRB), .c0_readData(c0_readData),
    .c1_req(c1_req), .c1_gnt(c1_gnt), .c1_wrAF(c1_wrAF), .c1_afAddress(c1_afAddress),
    .c1_afRead(c1_afRead), .c1_wrWB(c1_wrWB), .c1_writeData(c1_writeData),
    .c1_afFull(c1_afFull), .c1_wbFull(c1_wbFull), .c1_rbEmpty(c1_rbEmpty),
    .c1_rdRB(c1_rdRB), .c1_readData(c1_readData),
    .afFull(afFull), .wbFull(wbFull), .wrAF(wrAF), .afAddress(afAddress), .afRead(afRead),
    .wrWB(wrWB), .writeData(writeData), .rbEmpty(rbEmpty), .rdRB(rdRB), .readData(readData),
    .protoErr(protoErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic rec_t mkRec(input logic [1:0] k, input logic f, input logic [25:0] a,
                                 input logic [127:0] d);
    rec_t r;
    r.kind = k; r.flag = f; r.addr = a; r.data = d;
    return r;
  endfunction

  // Scoreboard: DUT-side events observed mid-cycle are matched against the
  // expectations queued by the stimulus tasks.
  always @(negedge clock) begin
    if (reset) begin
      evQ = {};
      if (wrWB) evQ.push_back(mkRec(K_WB, 1'b0, 26'd0, writeData));
      if (wrAF) evQ.push_back(mkRec(K_AF, afRead, afAddress, 128'd0));
      if (c0_rdRB && !c0_rbEmpty) evQ.push_back(mkRec(K_RD, 1'b0, 26'd0, c0_readData));
      if (c1_rdRB && !c1_rbEmpty) evQ.push_back(mkRec(K_RD, 1'b1, 26'd0, c1_readData));
      foreach (evQ[i]) begin
        checks++;
        if (expQ.size() == 0) begin
          fails++;
          $display("FAIL scoreboard unexpected event: got %h, required none", evQ[i]);
        end else begin
          expR = expQ.pop_front();
          if (evQ[i] !== expR) begin
            fails++;
            $display("FAIL scoreboard event: got %h, required %h", evQ[i], expR);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    c0_req = 0; c0_wrAF = 0; c0_afRead = 0; c0_wrWB = 0; c0_rdRB = 0;
    c0_afAddress = '0; c0_writeData = '0;
    c1_req = 0; c1_wrAF = 0; c1_afRead = 0; c1_wrWB = 0; c1_rdRB = 0;
    c1_afAddress = '0; c1_writeData = '0;
    afFull = 0; wbFull = 0; rbEmpty = 1; readData = '0;
  endtask

  task automatic test_reset();
    clearInputs();
    reset = 0;
    c0_req = 1; c0_wrAF = 1; c0_wrWB = 1; c0_rdRB = 1; c1_rdRB = 1; rbEmpty = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (c0_gnt !== 1'b0) begin fails++; $display("FAIL reset c0_gnt: got %b required 0", c0_gnt); end
    checks++; if (c1_gnt !== 1'b0) begin fails++; $display("FAIL reset c1_gnt: got %b required 0", c1_gnt); end
    checks++; if (c0_afFull !== 1'b1) begin fails++; $display("FAIL reset c0_afFull: got %b required 1", c0_afFull); end
    checks++; if (c0_wbFull !== 1'b1) begin fails++; $display("FAIL reset c0_wbFull: got %b required 1", c0_wbFull); end
    checks++; if (c1_afFull !== 1'b1) begin fails++; $display("FAIL reset c1_afFull: got %b required 1", c1_afFull); end
    checks++; if (c1_wbFull !== 1'b1) begin fails++; $display("FAIL reset c1_wbFull: got %b required 1", c1_wbFull); end
    checks++; if (c0_rbEmpty !== 1'b1) begin fails++; $display("FAIL reset c0_rbEmpty: got %b required 1", c0_rbEmpty); end
    checks++; if (c1_rbEmpty !== 1'b1) begin fails++; $display("FAIL reset c1_rbEmpty: got %b required 1", c1_rbEmpty); end
    checks++; if (wrAF !== 1'b0) begin fails++; $display("FAIL reset wrAF: got %b required 0", wrAF); end
    checks++; if (wrWB !== 1'b0) begin fails++; $display("FAIL reset wrWB: got %b required 0", wrWB); end
    checks++; if (rdRB !== 1'b0) begin fails++; $display("FAIL reset rdRB: got %b required 0", rdRB); end
    checks++; if (protoErr !== 1'b0) begin fails++; $display("FAIL reset protoErr: got %b required 0", protoErr); end
    clearInputs();
    step();
    reset = 1;
    step();
  endtask

  task automatic test_round_robin();
    int gq[$];
    int n;
    int heads[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    logic [127:0] d;
    for (int i = 0; i < 4; i++)
      expQ.push_back(mkRec(K_AF, 1'b1, (i % 2 == 0) ? 26'h0000100 : 26'h0000200, 128'd0));
    c0_req = 1; c0_wrAF = 1; c0_afRead = 1; c0_afAddress = 26'h0000100;
    c1_req = 1; c1_wrAF = 1; c1_afRead = 1; c1_afAddress = 26'h0000200;
    n = 0;
    for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
      @(negedge clock);
      checks++;
      if (c0_gnt && c1_gnt) begin fails++; $display("FAIL rr dual grant: got c0_gnt=1 c1_gnt=1, required at most one"); end
      if (c0_gnt) begin gq.push_back(0); n++; end
      else if (c1_gnt) begin gq.push_back(1); n++; end
      if (n < 4) step();
    end
    step();
    clearInputs();
    checks++; if (gq.size() != 4) begin fails++; $display("FAIL rr grant count: got %0d required 4", gq.size()); end
    foreach (gq[i]) begin
      checks++;
      if (gq[i] != (i % 2)) begin fails++; $display("FAIL rr grant order[%0d]: got %0d required %0d", i, gq[i], i % 2); end
    end
    // Drain the four lines in issue order: 0,1,0,1 with two beats each.
    rbEmpty = 0; c0_rdRB = 1; c1_rdRB = 1;
    for (int i = 0; i < 8; i++) begin
      d = {32'hAB00_0000 + 32'(i), 96'h0};
      readData = d;
      expQ.push_back(mkRec(K_RD, heads[i][0], 26'd0, d));
      step();
    end
    clearInputs();
    checks++; if (expQ.size() != 0) begin fails++; $display("FAIL rr pending events: got %0d left, required 0", expQ.size()); end
  endtask

  task automatic test_write();
    c0_req = 1;
    c1_wrWB = 1; c1_writeData = {4{32'hBAD0_BAD0}};
    step();
    @(negedge clock);
    checks++; if (c0_gnt !== 1'b1) begin fails++; $display("FAIL write gnt0 rise: got %b required 1", c0_gnt); end
    checks++; if (c1_wbFull !== 1'b1) begin fails++; $display("FAIL write c1_wbFull: got %b required 1", c1_wbFull); end
    checks++; if (c1_afFull !== 1'b1) begin fails++; $display("FAIL write c1_afFull: got %b required 1", c1_afFull); end
    checks++; if (c0_wbFull !== 1'b0) begin fails++; $display("FAIL write c0_wbFull: got %b required 0", c0_wbFull); end
    step();
    c0_wrWB = 1; c0_writeData = {4{32'h1111_0001}};
    expQ.push_back(mkRec(K_WB, 1'b0, 26'd0, {4{32'h1111_0001}}));
    step();
    c0_writeData = {4{32'h2222_0002}};
    expQ.push_back(mkRec(K_WB, 1'b0, 26'd0, {4{32'h2222_0002}}));
    step();
    c0_wrWB = 0; c0_wrAF = 1; c0_afRead = 0; c0_afAddress = 26'h0000040;
    expQ.push_back(mkRec(K_AF, 1'b0, 26'h0000040, 128'd0));
    step();
    c0_wrAF = 0; c0_req = 0;
    @(negedge clock);
    checks++; if (c0_gnt !== 1'b0) begin fails++; $display("FAIL write gnt0 drop: got %b required 0", c0_gnt); end
    checks++; if (protoErr !== 1'b0) begin fails++; $display("FAIL write protoErr: got %b required 0", protoErr); end
    step();
    clearInputs();
    checks++; if (expQ.size() != 0) begin fails++; $display("FAIL write pending events: got %0d left, required 0", expQ.size()); end
  endtask

  task automatic test_read_order();
    logic [127:0] d;
    c1_req = 1; c1_wrAF = 1; c1_afRead = 1; c1_afAddress = 26'h0000300;
    expQ.push_back(mkRec(K_AF, 1'b1, 26'h0000300, 128'd0));
    step();
    step();
    c1_req = 0; c1_wrAF = 0;
    c0_req = 1; c0_wrAF = 1; c0_afRead = 1; c0_afAddress = 26'h0000380;
    expQ.push_back(mkRec(K_AF, 1'b1, 26'h0000380, 128'd0));
    step();
    step();
    clearInputs();
    rbEmpty = 0; c0_rdRB = 1; c1_rdRB = 1;
    for (int i = 0; i < 4; i++) begin
      d = {96'h0, 32'hC0DE_0000 + 32'(i)};
      readData = d;
      expQ.push_back(mkRec(K_RD, (i < 2), 26'd0, d));
      @(negedge clock);
      checks++; if (c0_rbEmpty !== (i < 2)) begin fails++; $display("FAIL readorder c0_rbEmpty beat %0d: got %b required %b", i + 1, c0_rbEmpty, (i < 2)); end
      checks++; if (c1_rbEmpty !== (i >= 2)) begin fails++; $display("FAIL readorder c1_rbEmpty beat %0d: got %b required %b", i + 1, c1_rbEmpty, (i >= 2)); end
      checks++; if (rdRB !== 1'b1) begin fails++; $display("FAIL readorder rdRB beat %0d: got %b required 1", i + 1, rdRB); end
      step();
    end
    clearInputs();
    checks++; if (expQ.size() != 0) begin fails++; $display("FAIL readorder pending events: got %0d left, required 0", expQ.size()); end
  endtask

  task automatic test_tag_full();
    int n;
    logic [127:0] d;
    for (int i = 0; i < 8; i++) expQ.push_back(mkRec(K_AF, 1'b1, 26'h0000400, 128'd0));
    c0_req = 1; c0_wrAF = 1; c0_afRead = 1; c0_afAddress = 26'h0000400;
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      @(negedge clock);
      if (wrAF) n++;
      if (n < 8) step();
    end
    checks++; if (n != 8) begin fails++; $display("FAIL tagfull reads issued: got %0d required 8", n); end
    step();
    step();
    @(negedge clock);
    checks++; if (c0_gnt !== 1'b1) begin fails++; $display("FAIL tagfull gnt0: got %b required 1", c0_gnt); end
    checks++; if (c0_afFull !== 1'b1) begin fails++; $display("FAIL tagfull afFull at 8: got %b required 1", c0_afFull); end
    checks++; if (wrAF !== 1'b0) begin fails++; $display("FAIL tagfull wrAF blocked: got %b required 0", wrAF); end
    step();
    c0_wrAF = 0; rbEmpty = 0; c0_rdRB = 1;
    for (int i = 0; i < 16; i++) begin
      d = {32'h0F00_0000 + 32'(i), 96'h5};
      readData = d;
      expQ.push_back(mkRec(K_RD, 1'b0, 26'd0, d));
      if (i == 2) begin
        @(negedge clock);
        checks++; if (c0_afFull !== 1'b0) begin fails++; $display("FAIL tagfull afFull after drain: got %b required 0", c0_afFull); end
        checks++; if (c0_gnt !== 1'b1) begin fails++; $display("FAIL tagfull gnt0 held: got %b required 1", c0_gnt); end
        c0_req = 0;
      end
      step();
    end
    c0_rdRB = 0;
    @(negedge clock);
    checks++; if (c0_rbEmpty !== 1'b1) begin fails++; $display("FAIL tagfull rbEmpty when tags empty: got %b required 1", c0_rbEmpty); end
    step();
    clearInputs();
    checks++; if (expQ.size() != 0) begin fails++; $display("FAIL tagfull pending events: got %0d left, required 0", expQ.size()); end
  endtask

  task automatic test_proto_err();
    c0_req = 1;
    step();
    c0_wrWB = 1; c0_writeData = {4{32'h3333_0003}};
    expQ.push_back(mkRec(K_WB, 1'b0, 26'd0, {4{32'h3333_0003}}));
    step();
    c0_wrWB = 0; c0_wrAF = 1; c0_afRead = 0; c0_afAddress = 26'h0000080;
    expQ.push_back(mkRec(K_AF, 1'b0, 26'h0000080, 128'd0));
    @(negedge clock);
    checks++; if (protoErr !== 1'b0) begin fails++; $display("FAIL protoerr early: got %b required 0", protoErr); end
    step();
    clearInputs();
    @(negedge clock);
    checks++; if (protoErr !== 1'b1) begin fails++; $display("FAIL protoerr set: got %b required 1", protoErr); end
    checks++; if (c0_gnt !== 1'b0) begin fails++; $display("FAIL protoerr gnt0 drop: got %b required 0", c0_gnt); end
    repeat (4) step();
    @(negedge clock);
    checks++; if (protoErr !== 1'b1) begin fails++; $display("FAIL protoerr sticky: got %b required 1", protoErr); end
    checks++; if (expQ.size() != 0) begin fails++; $display("FAIL protoerr pending events: got %0d left, required 0", expQ.size()); end
    step();
  endtask

  task automatic test_reset_midflight();
    int n;
    for (int i = 0; i < 3; i++) expQ.push_back(mkRec(K_AF, 1'b1, 26'h0000500, 128'd0));
    c1_req = 1; c1_wrAF = 1; c1_afRead = 1; c1_afAddress = 26'h0000500;
    n = 0;
    for (int cyc = 0; cyc < 30 && n < 3; cyc++) begin
      @(negedge clock);
      if (wrAF) n++;
      if (n < 3) step();
    end
    step();
    c1_wrAF = 0;
    rbEmpty = 0;
    step();
    @(negedge clock);
    checks++; if (n != 3) begin fails++; $display("FAIL midreset reads issued: got %0d required 3", n); end
    checks++; if (c1_gnt !== 1'b1) begin fails++; $display("FAIL midreset pre gnt1: got %b required 1", c1_gnt); end
    checks++; if (c1_rbEmpty !== 1'b0) begin fails++; $display("FAIL midreset pre c1_rbEmpty: got %b required 0", c1_rbEmpty); end
    checks++; if (expQ.size() != 0) begin fails++; $display("FAIL midreset pending events: got %0d left, required 0", expQ.size()); end
    #1;
    reset = 0;
    c1_rdRB = 1;
    #1;
    checks++; if (dut.tagCount !== '0) begin fails++; $display("FAIL midreset tagCount: got %0d required 0", dut.tagCount); end
    checks++; if (c1_gnt !== 1'b0) begin fails++; $display("FAIL midreset gnt1: got %b required 0", c1_gnt); end
    checks++; if (c0_rbEmpty !== 1'b1) begin fails++; $display("FAIL midreset c0_rbEmpty: got %b required 1", c0_rbEmpty); end
    checks++; if (c1_rbEmpty !== 1'b1) begin fails++; $display("FAIL midreset c1_rbEmpty: got %b required 1", c1_rbEmpty); end
    checks++; if (rdRB !== 1'b0) begin fails++; $display("FAIL midreset rdRB: got %b required 0", rdRB); end
    checks++; if (protoErr !== 1'b0) begin fails++; $display("FAIL midreset protoErr: got %b required 0", protoErr); end
    checks++; if (c1_afFull !== 1'b1) begin fails++; $display("FAIL midreset c1_afFull: got %b required 1", c1_afFull); end
    step();
    clearInputs();
    reset = 1;
    step();
  endtask

  initial begin
    reset = 0;
    clearInputs();
    test_reset();
    test_round_robin();
    test_write();
    test_read_order();
    test_tag_full();
    test_proto_err();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
